// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared state encoding, mode/shift constants and Booth decode for the multiply sequencer.
package mult_seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      EVAL  = 3'd2,
      SHIFT = 3'd3,
      WB_LO = 3'd4,
      WB_HI = 3'd5
   } state_t;

   localparam logic MODE_UNSIGNED = 1'b0;
   localparam logic MODE_BOOTH    = 1'b1;
   localparam logic SR_SEL_LOGIC  = 1'b0;
   localparam logic SR_SEL_ARITH  = 1'b1;

   // returns {add_en, sub} for one evaluation step
   function automatic logic [1:0] eval_op(input logic mode, input logic q0, input logic qm1);
      return mode == MODE_BOOTH ? {q0 ^ qm1, q0 & ~qm1} : {q0, 1'b0};
   endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// mult_seq_if: control/datapath handshake bundle around the multiply sequencer.
interface mult_seq_if;
   logic start, mode, abort, q0;
   logic busy, done, ldm, ldq, clr_a, add_en, sub, sr, sr_sel, rf_en, wb_hi;
   modport master (
      output start, mode, abort, q0,
      input  busy, done, ldm, ldq, clr_a, add_en, sub, sr, sr_sel, rf_en, wb_hi
   );
   modport slave (
      input  start, mode, abort, q0,
      output busy, done, ldm, ldq, clr_a, add_en, sub, sr, sr_sel, rf_en, wb_hi
   );
endinterface

// File: rtl/mult_iter_counter.sv
// mult_iter_counter: loadable iteration down-counter; last flags the final shift.
module mult_iter_counter #(
   parameter int WIDTH = 16
) (
   input  logic CLK,
   input  logic RST,
   input  logic load,
   input  logic dec,
   output logic last
);
   localparam int CW = $clog2(WIDTH + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge CLK or negedge RST)
      if (!RST) cnt <= '0;
      else if (load) cnt <= CW'(WIDTH);
      else if (dec) cnt <= cnt - 1'b1;
   assign last = cnt == CW'(1);
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: steps the shared A/Q multiply datapath through load, WIDTH add/shift
// iterations and a low/high writeback, in unsigned shift-add or radix-2 Booth mode.
module mult_sequencer
   import mult_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic       CLK,
   input  logic       RST,
   mult_seq_if.slave  bus
);
   state_t state, nxt;
   logic   mode_r, qm1, last;

   mult_iter_counter #(.WIDTH(WIDTH)) u_cnt (
      .CLK  (CLK),
      .RST  (RST),
      .load (state == LOAD),
      .dec  (state == SHIFT),
      .last (last)
   );

   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         state  <= IDLE;
         mode_r <= MODE_UNSIGNED;
         qm1    <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && bus.start) mode_r <= bus.mode;
         if (state == LOAD) qm1 <= 1'b0;
         else if (state == SHIFT) qm1 <= bus.q0;
      end

   // outputs decode from the current state even in an abort cycle
   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE:    nxt = bus.start ? LOAD : IDLE;
         LOAD:    nxt = EVAL;
         EVAL:    nxt = SHIFT;
         SHIFT:   nxt = last ? WB_LO : EVAL;
         WB_LO:   nxt = WB_HI;
         default: nxt = IDLE;
      endcase
      if (state != IDLE && bus.abort) nxt = IDLE;
      bus.busy   = state != IDLE;
      bus.done   = state == WB_HI;
      bus.ldm    = state == LOAD;
      bus.ldq    = state == LOAD;
      bus.clr_a  = state == LOAD;
      {bus.add_en, bus.sub} = state == EVAL ? eval_op(mode_r, bus.q0, qm1) : 2'b00;
      bus.sr     = state == SHIFT;
      bus.sr_sel = state == SHIFT ? mode_r : SR_SEL_LOGIC;
      bus.rf_en  = state == WB_LO || state == WB_HI;
      bus.wb_hi  = state == WB_HI;
   end
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed checks of the multiply sequencer cycle by cycle,
// with a small Q-register model supplying Q0.
module tb_mult_sequencer;
   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] qreg = '0;
   logic [15:0] qv_load = '0;
   logic [10:0] outs;

   mult_seq_if bus();

   mult_sequencer #(.WIDTH(16)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK)
      if (bus.ldq) qreg <= qv_load;
      else if (bus.sr) qreg <= qreg >> 1;

   assign bus.q0 = qreg[0];
   assign outs = {bus.busy, bus.done, bus.ldm, bus.ldq, bus.clr_a, bus.add_en,
                  bus.sub, bus.sr, bus.sr_sel, bus.rf_en, bus.wb_hi};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // expected {busy,done,ldm,ldq,clr_a,add_en,sub,sr,sr_sel,rf_en,wb_hi} in cycle c after START
   function automatic logic [10:0] expv(input int c, input logic md, input logic [15:0] qv);
      logic [16:0] ext;
      logic        b, p, add, sub;
      int          i;
      ext = {qv, 1'b0};
      if (c == 1) return 11'b1_0_111_00_0_0_00;
      if (c >= 2 && c <= 33 && c % 2 == 0) begin
         i   = c / 2;
         b   = ext[i];
         p   = ext[i-1];
         add = md ? b ^ p : b;
         sub = md ? b & ~p : 1'b0;
         return {1'b1, 1'b0, 3'b000, add, sub, 1'b0, 1'b0, 2'b00};
      end
      if (c >= 3 && c <= 33) return {1'b1, 1'b0, 3'b000, 2'b00, 1'b1, md, 2'b00};
      if (c == 34) return 11'b1_0_000_00_0_0_10;
      if (c == 35) return 11'b1_1_000_00_0_0_11;
      return '0;
   endfunction

   // caller must be 1ns into a cycle; START is asserted in that cycle
   task automatic op(input logic md, input logic [15:0] qv, input int abort_c,
                     input logic start_abort, input int s1, input int s2);
      logic seen;
      qv_load   = qv;
      bus.mode  = md;
      bus.start = 1'b1;
      bus.abort = start_abort;
      @(posedge CLK); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.mode  = ~md;
      for (int c = 1; c <= 35; c++) begin
         if (c > 1) begin
            @(posedge CLK); #1;
         end
         chk($sformatf("m%0d q%h c%0d", md, qv, c), 32'(outs), 32'(expv(c, md, qv)));
         bus.start = (c == s1 || c == s2);
         bus.abort = (c == abort_c);
         if (c == abort_c) begin
            @(posedge CLK); #1;
            bus.abort = 1'b0;
            chk($sformatf("abort_idle c%0d", c + 1), 32'(outs), 32'd0);
            seen = 1'b0;
            repeat (40) begin
               @(posedge CLK); #1;
               seen = seen | bus.rf_en | bus.done | bus.busy;
            end
            chk("abort_quiet", 32'(seen), 32'd0);
            return;
         end
      end
      bus.start = 1'b0;
      @(posedge CLK); #1;
      chk($sformatf("post_idle m%0d q%h", md, qv), 32'(outs), 32'd0);
   endtask

   initial begin
      logic seen;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.mode  = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset_outs", 32'(outs), 32'd0);
      RST = 1'b1;
      @(posedge CLK); #1;
      bus.abort = 1'b1;
      @(posedge CLK); #1;
      bus.abort = 1'b0;
      chk("abort_in_idle", 32'(outs), 32'd0);

      op(1'b0, 16'h0005, 0, 1'b0, 0, 0);
      op(1'b1, 16'hFFFF, 0, 1'b0, 0, 0);
      op(1'b1, 16'h0002, 0, 1'b0, 0, 0);
      op(1'b1, 16'hA5C3, 0, 1'b1, 0, 0);
      op(1'b0, 16'h8001, 0, 1'b0, 5, 20);
      op(1'b1, 16'h1234, 0, 1'b0, 0, 0);
      op(1'b0, 16'hFFFF, 10, 1'b0, 0, 0);
      op(1'b0, 16'h0005, 0, 1'b0, 0, 0);

      qv_load   = 16'h00FF;
      bus.mode  = 1'b1;
      bus.start = 1'b1;
      @(posedge CLK); #1;
      bus.start = 1'b0;
      repeat (6) begin
         @(posedge CLK); #1;
      end
      chk("pre_rst_shift", 32'(outs), 32'(expv(7, 1'b1, 16'h00FF)));
      RST = 1'b0;
      #1;
      chk("rst_async", 32'(outs), 32'd0);
      repeat (2) @(posedge CLK);
      #1;
      RST  = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(posedge CLK); #1;
         seen = seen | (|outs);
      end
      chk("rst_quiet", 32'(seen), 32'd0);
      op(1'b1, 16'h00FF, 0, 1'b0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle sequencer for the shared A/Q shift-register multiply datapath: C, A, Q, M registers, the adder/subtractor and the right shifter. The control unit hands it a multiply via a START/DONE handshake. It then steps the datapath through load, WIDTH add/shift iterations, and a two-cycle low/high product writeback to the register file. Two modes are supported: unsigned shift-add and signed radix-2 Booth.

## Interface
- WIDTH, 16: operand width and iteration count; legal range is WIDTH ≥ 2.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  request a multiply; sampled only in IDLE.
- MODE  in  1  0 = unsigned shift-add, 1 = Booth signed; latched with START.
- ABORT  in  1  cancel the operation in flight.
- Q0  in  1  current LSB of the Q register; the datapath drives it from a register.
- BUSY  out  1  high from LOAD through WB_HI.
- DONE  out  1  one-cycle pulse in the WB_HI cycle.
- LDM  out  1  load the multiplicand into M.
- LDQ  out  1  load the multiplier into Q.
- CLR_A  out  1  clear C and A.
- ADD_EN  out  1  A ← A ± M, with carry into C.
- SUB  out  1  selects subtract when ADD_EN is high.
- SR  out  1  shift {C,A,Q} right by one.
- SR_SEL  out  1  0 = shift C into A MSB, 1 = arithmetic (A MSB replicated).
- RF_EN  out  1  register-file write enable.
- WB_HI  out  1  writeback data select: 0 = Q (low word), 1 = A (high word).

## Operation
- States: IDLE, LOAD, EVAL, SHIFT, WB_LO, WB_HI.
- Internal registers: state; mode_r; qm1 (Booth Q₋₁); cnt, a down-counter of width $clog2(WIDTH+1).
- IDLE: all outputs 0. START=1 → LOAD and mode_r ← MODE.
- LOAD:
  - LDM=LDQ=CLR_A=1.
  - qm1 ← 0, cnt ← WIDTH.
  - Next state: EVAL.
- EVAL (ADD_EN and SUB are Mealy on Q0):
  - Unsigned: ADD_EN=Q0, SUB=0.
  - Booth: {Q0,qm1}=10 → ADD_EN=1, SUB=1; 01 → ADD_EN=1, SUB=0; 00/11 → ADD_EN=0.
  - Next state: SHIFT.
- SHIFT:
  - SR=1, SR_SEL=mode_r.
  - qm1 ← Q0, the pre-shift value.
  - cnt ← cnt−1.
  - If cnt==1 → WB_LO, else EVAL.
- WB_LO: RF_EN=1, WB_HI=0 → WB_HI.
- WB_HI: RF_EN=1, WB_HI=1, DONE=1 → IDLE.
- ABORT=1 in any non-IDLE state:
  - Next state is IDLE.
  - That cycle's outputs are still driven by the current state.
  - No later RF_EN or DONE is produced.
- START while BUSY is ignored and not queued.
- ABORT in IDLE has no effect.
- START and ABORT both high in IDLE: START is taken, ABORT is ignored.
- Outputs other than ADD_EN/SUB are pure state decode (Moore).

## Timing
- START sampled at edge k → LOAD in cycle k+1.
- EVAL/SHIFT pairs occupy cycles k+2 … k+2W+1.
- WB_LO in k+2W+2; WB_HI with DONE in k+2W+3.
- WIDTH=16: DONE in the 35th cycle after the START edge.
- Busy-to-idle: BUSY falls in the cycle after WB_HI. START may be asserted in that cycle and is accepted; the minimum issue interval is 2W+4 cycles.
- Reset value of every output is 0; state=IDLE, cnt=0, qm1=0, mode_r=0.
- Reset asserted mid-operation forces all outputs to 0 asynchronously, with no partial writeback. After release the block waits in IDLE for START.

## Structure
- Shared package mult_seq_pkg holds:
  - the state encoding constants (IDLE=0 … WB_HI=5);
  - MODE_UNSIGNED=0 and MODE_BOOTH=1;
  - SR_SEL_LOGIC=0 and SR_SEL_ARITH=1.
- One natural sub-module, mult_iter_counter: a loadable down-counter (load, dec, last = cnt==1), parameterised by WIDTH.
- The rest is a single FSM plus output decode.

## Test plan
- Unsigned, WIDTH=16, M=3, Q=5, START pulse:
  - ADD_EN high in EVAL iterations 1 and 3 only; SUB never asserted.
  - RF_EN in cycles 34 and 35, with WB_HI=0 then 1.
  - DONE in cycle 35.
- Booth, Q=0xFFFF: ADD_EN=SUB=1 only in iteration 1; iterations 2–16 have ADD_EN=0; SR_SEL=1 in every SHIFT.
- Booth, Q=0x0002:
  - Iteration 1 has ADD_EN=0.
  - Iteration 2 has ADD_EN=1, SUB=1.
  - Iteration 3 has ADD_EN=1, SUB=0.
  - Iterations 4–16 have ADD_EN=0.
- ABORT in cycle 10: IDLE in cycle 11, BUSY=0; RF_EN and DONE never asserted; a fresh START gives the full 35-cycle sequence.
- START pulsed in cycles 5 and 20 of an operation is ignored (one DONE only). START in the cycle right after DONE starts a new LOAD.
- RST low during a SHIFT cycle:
  - All outputs drop to 0 before the next clock edge.
  - After release, no activity until START; the next operation completes in 35 cycles.
